// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and a
// constant-width helper used to size the bit counter.
package serial_adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bits needed to hold values 0..value-1; never returns less than one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit full adder, purely combinational; the arithmetic step shared by
// the serial arithmetic blocks.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder (LSB first) behind a start/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output o_ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CW = clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_sumSh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_count;

    logic             w_s;
    logic             w_c;
    logic             w_accept;
    logic             w_lastBit;
    logic [WIDTH-1:0] w_sumNext;
    logic             w_unusedSumLsb;

    full_adder_cell u_fa (
        .i_a    (r_opA[0]),
        .i_b    (r_opB[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    assign w_accept  = i_start && (r_state != ST_RUN);
    assign w_lastBit = (r_state == ST_RUN) && (r_count == CW'(WIDTH - 1));

    // The shift register's LSB is overwritten garbage until the final shift, so it is never consumed.
    generate
        if (WIDTH == 1) begin : g_oneBit
            assign w_sumNext = w_s;
        end else begin : g_multiBit
            assign w_sumNext = {w_s, r_sumSh[WIDTH-1:1]};
        end
    endgenerate

    assign w_unusedSumLsb = r_sumSh[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_opA   <= '0;
            r_opB   <= '0;
            r_sumSh <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_opA   <= r_opA >> 1;
                    r_opB   <= r_opB >> 1;
                    r_carry <= w_c;
                    r_sumSh <= w_sumNext;
                    r_count <= r_count + CW'(1);
                    if (w_lastBit) begin
                        r_state <= ST_DONE;
                        r_sum   <= w_sumNext;
                        r_cout  <= w_c;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_opA   <= i_a;
                        r_opB   <= i_b;
                        r_carry <= i_cin;
                        r_sumSh <= '0;
                        r_count <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last bit the registered carry is the carry into the MSB.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_lastBit) begin
            r_ovf <= r_carry ^ w_c;
        end
    end

    assign o_ovf = r_ovf;
`endif

    assign o_busy = (r_state == ST_RUN);
    assign o_done = (r_state == ST_DONE);
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed literal cases, randomized
// traffic against a countdown/arithmetic reference model, and a WIDTH=1 instance.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk    = 1'b0;
    logic         rstN   = 1'b0;
    logic         start  = 1'b0;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         cin    = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic         start1 = 1'b0;
    logic [0:0]   a1     = '0;
    logic [0:0]   b1     = '0;
    logic         cin1   = 1'b0;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         ovf1;
`endif

    int errors = 0;
    int checks = 0;
    bit compareEn = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .o_ovf   (ovf),
`endif
        .o_cout  (cout)
    );

    serial_adder #(.WIDTH(1)) dutOne (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_start (start1),
        .i_a     (a1),
        .i_b     (b1),
        .i_cin   (cin1),
        .o_busy  (busy1),
        .o_done  (done1),
        .o_sum   (sum1),
`ifdef SERIAL_ADDER_OVF_EN
        .o_ovf   (ovf1),
`endif
        .o_cout  (cout1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Signed overflow from plain integer arithmetic on the two's-complement operands.
    function automatic logic signedOvf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sx;
        int sy;
        int total;
        sx    = $signed(x);
        sy    = $signed(y);
        total = sx + sy + int'(c);
        return (total > 127) || (total < -128);
    endfunction

    // Reference model: a countdown of remaining busy cycles plus the held result.
    int           mBusyLeft = 0;
    logic [W:0]   mPending  = '0;
    logic         mPendOvf  = 1'b0;
    logic         mDone     = 1'b0;
    logic [W-1:0] mSum      = '0;
    logic         mCout     = 1'b0;
    logic         mOvf      = 1'b0;
    logic         mAccept;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mBusyLeft = 0;
            mPending  = '0;
            mPendOvf  = 1'b0;
            mDone     = 1'b0;
            mSum      = '0;
            mCout     = 1'b0;
            mOvf      = 1'b0;
        end else begin
            mAccept = start && (mBusyLeft == 0);
            mDone   = 1'b0;
            if (mBusyLeft > 0) begin
                mBusyLeft = mBusyLeft - 1;
                if (mBusyLeft == 0) begin
                    mDone         = 1'b1;
                    {mCout, mSum} = mPending;
                    mOvf          = mPendOvf;
                end
            end
            if (mAccept) begin
                mPending  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                mPendOvf  = signedOvf(a, b, cin);
                mBusyLeft = W;
            end
        end
    end

    always @(negedge clk) begin
        if (compareEn) begin
            checkOutput("busy", 32'(busy), 32'(mBusyLeft > 0));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("sum", 32'(sum), 32'(mSum));
            checkOutput("cout", 32'(cout), 32'(mCout));
`ifdef SERIAL_ADDER_OVF_EN
            checkOutput("ovf", 32'(ovf), 32'(mOvf));
`endif
        end
    end

    // Must be called at a falling edge; returns edges from accept to done and busy cycles seen.
    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                                 input bit pulseWhileBusy, output int lat, output int busyCycles);
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = ic;
        @(negedge clk);
        lat        = 0;
        busyCycles = 0;
        start      = 1'b0;
        a          = W'($urandom);
        b          = W'($urandom);
        cin        = 1'($urandom);
        while (!done && lat < 20) begin
            if (busy) busyCycles++;
            if (pulseWhileBusy && (lat == 2 || lat == 4)) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
                cin   = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) checkOutput("done timeout", 32'(done), 32'd1);
    endtask

    task automatic runCheck(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                            input bit pulseWhileBusy, input logic [W-1:0] expSum, input logic expCout,
                            input logic expOvf);
        int lat;
        int busyCycles;
        applyStimulus(ia, ib, ic, pulseWhileBusy, lat, busyCycles);
        checkOutput({name, " latency"}, 32'(lat), 32'd8);
        checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'd8);
        checkOutput({name, " sum"}, 32'(sum), 32'(expSum));
        checkOutput({name, " cout"}, 32'(cout), 32'(expCout));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput({name, " ovf"}, 32'(ovf), 32'(expOvf));
`else
        if (expOvf === 1'bx) $display("[TB] note: unknown overflow expectation for %s", name);
`endif
    endtask

    initial begin
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sum", 32'(sum), 32'd0);
        checkOutput("reset cout", 32'(cout), 32'd0);
        rstN = 1'b1;
        compareEn = 1'b1;
        @(negedge clk);

        runCheck("5+3", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
        runCheck("FF+1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        runCheck("80+80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        runCheck("7F+1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        start = 1'b1;
        a     = 8'h55;
        b     = 8'hAA;
        cin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rstN = 1'b0;
        #1;
        checkOutput("midrun reset busy", 32'(busy), 32'd0);
        checkOutput("midrun reset done", 32'(done), 32'd0);
        checkOutput("midrun reset sum", 32'(sum), 32'd0);
        checkOutput("midrun reset cout", 32'(cout), 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        runCheck("A5+5A", 8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        runCheck("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        runCheck("ignored starts", 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
        runCheck("b2b first", 8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0);
        runCheck("b2b second", 8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

        for (int c = 0; c < 600; c++) begin
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            a1     = 1'(i >> 2);
            b1     = 1'(i >> 1);
            cin1   = 1'(i);
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            checkOutput("w1 busy", 32'(busy1), 32'd1);
            checkOutput("w1 early done", 32'(done1), 32'd0);
            @(negedge clk);
            checkOutput("w1 done", 32'(done1), 32'd1);
            checkOutput("w1 result", 32'({cout1, sum1}),
                        32'(((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1)));
        end

        compareEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
